apb_req_sequencer: RTL and testbench
====================================

Name: apb_req_sequencer

Overview:
- Upstream command stage for apb_master. Buffers host read/write requests in a FIFO and issues them one at a time on the master's start/write/addr/wdata inputs.
- Waits for the master's pready completion, then returns read data and the error flag through a valid/ready response port.
- Sits between the system-side request source and apb_master. It is the only driver of the master's start.

Parameters:
- AW, 8, address width (matches apb_master addr).
- DW, 8, data width (matches apb_master wdata/prdata).
- DEPTH, 4, request FIFO entries; power of 2, ≥2.
- TIMEOUT, 16, WAIT-state cycle limit; used only with the optional feature.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request offered.
- req_ready  out  1  FIFO can accept; equals !full.
- req_write  in  1  1=write, 0=read.
- req_addr  in  AW  request address.
- req_wdata  in  DW  write data; ignored for reads.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  DW  read data; 0 for writes.
- rsp_err  out  1  pslverr (or timeout) of the completed transfer.
- m_start  out  1  one-cycle pulse to apb_master start.
- m_write  out  1  to apb_master write.
- m_addr  out  AW  to apb_master addr.
- m_wdata  out  DW  to apb_master wdata.
- m_prdata  in  DW  from apb_master prdata.
- m_pready  in  1  from apb_master pready; transfer complete.
- m_pslverr  in  1  from apb_master pslverr.
- busy  out  1  state != IDLE or FIFO non-empty.
- fifo_count  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset (sync, high):
  - FIFO emptied; fifo_count=0, req_ready=1.
  - State=IDLE.
  - m_start=0, m_write=0, m_addr=0, m_wdata=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
- Push: req_valid&&req_ready at edge writes {write,addr,wdata}. The entry is poppable from the next cycle.
- Pop and push in the same cycle (non-full FIFO): both occur; count unchanged.
- Full: req_ready=0; req_valid is ignored, no overwrite.
- Read/write pointers wrap modulo DEPTH. Full/empty are derived from an extra pointer bit or the count.
- State machine:
  - IDLE: if FIFO non-empty and response slot free (rsp_valid==0 || rsp_ready==1):
    - pop head;
    - register m_write/m_addr/m_wdata;
    - m_start<=1;
    - go to ISSUE.
    - Otherwise stay in IDLE.
  - ISSUE: exactly one cycle with m_start=1; m_pready is ignored. Then m_start<=0 and go to WAIT.
  - WAIT: m_write/m_addr/m_wdata stay held. On m_pready=1:
    - rsp_valid<=1;
    - rsp_rdata<=(m_write?0:m_prdata);
    - rsp_err<=m_pslverr;
    - go to IDLE.
    - Otherwise stay in WAIT.
- Response slot: rsp_valid clears on rsp_valid&&rsp_ready unless a new completion loads in the same cycle. In that case the new values load and rsp_valid stays 1.
- Latency:
  - Push at edge N → m_start high during cycle N+1→N+2 (earliest).
  - m_pready at edge M → rsp_valid=1 after edge M.
  - Back-to-back: the next m_start asserts the cycle after the return to IDLE.
- At most one transfer is outstanding; requests are issued in strict FIFO order.
- m_pready while in IDLE or ISSUE is ignored.
- Reset mid-transfer: state, FIFO and response are cleared at that edge; a late m_pready afterwards is ignored.

Optional Feature:
- Macro: APB_REQ_SEQ_TIMEOUT_EN.
- Defined:
  - A WAIT-cycle counter clears on entry to WAIT.
  - If TIMEOUT cycles elapse in WAIT without m_pready, complete as if m_pready had arrived: rsp_err=1, rsp_rdata=0, go to IDLE.
  - m_pready on the exact cycle the counter reaches TIMEOUT takes priority (normal completion).
- Undefined: no counter; WAIT waits indefinitely.

Test Plan:
- Reset then idle → req_ready=1, fifo_count=0, m_start=0, rsp_valid=0, busy=0.
- Push write addr=0x10 wdata=0xFF; model pready 2 cycles after start with pslverr=0 → one m_start pulse, m_addr=0x10, m_write=1, m_wdata=0xFF; rsp_valid=1, rsp_err=0, rsp_rdata=0x00.
- Push read 0x10 then read 0x80 back-to-back; model returns 0xFF then 0xA5; rsp_ready=1 → two start pulses in order; responses 0xFF then 0xA5; no second start before first pready.
- Hold rsp_ready=0 with 5 pushes at DEPTH=4 → req_ready=0 after 4 entries accepted (5th refused); only one transfer completes; no further m_start until rsp_ready=1.
- Read 0x80 with m_pslverr=1 on completion → rsp_err=1, rsp_rdata=m_prdata.
- Assert reset during WAIT with 2 queued, then pulse pready → fifo_count=0, rsp_valid=0, no response emitted. With APB_REQ_SEQ_TIMEOUT_EN and no pready → rsp_err=1 exactly TIMEOUT cycles after entering WAIT.

Source files
------------

// File: rtl/apb_req_sequencer_if.sv
// Bundle of the host request/response port and the apb_master command port of apb_req_sequencer.
// The sequencer connects through the slave modport; the surrounding system uses master.
interface apb_req_sequencer_if #(
  parameter int unsigned AW    = 8,
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [AW-1:0]   req_addr;
  logic [DW-1:0]   req_wdata;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic            m_start;
  logic            m_write;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  logic [DW-1:0]   m_prdata;
  logic            m_pready;
  logic            m_pslverr;
  logic            busy;
  logic [CntW-1:0] fifo_count;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready, m_prdata, m_pready, m_pslverr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, m_start, m_write, m_addr, m_wdata, busy,
           fifo_count
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready, m_prdata, m_pready, m_pslverr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, m_start, m_write, m_addr, m_wdata, busy,
           fifo_count
  );
endinterface

// File: rtl/apb_req_sequencer.sv
// apb_req_sequencer: buffers host requests in a FIFO and issues them one at a time to apb_master.
// Define APB_REQ_SEQ_TIMEOUT_EN to end a WAIT with an error after TIMEOUT cycles without pready.
module apb_req_sequencer #(
  parameter int unsigned AW      = 8,
  parameter int unsigned DW      = 8,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  apb_req_sequencer_if.slave bus_io
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned EntW = 1 + AW + DW;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e          state_q, state_d;
  logic [EntW-1:0] mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            m_start_q, m_start_d;
  logic            m_write_q, m_write_d;
  logic [AW-1:0]   m_addr_q, m_addr_d;
  logic [DW-1:0]   m_wdata_q, m_wdata_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_err_q, rsp_err_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic            full, empty, push, pop, slot_free;

`ifdef APB_REQ_SEQ_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TIMEOUT == 0)) begin : g_param_check
    $error("apb_req_sequencer: DEPTH must be a power of 2 >= 2 and TIMEOUT nonzero");
  end

  assign full      = (count_q == CntW'(DEPTH));
  assign empty     = (count_q == '0);
  assign push      = bus_io.req_valid && !full;
  // A completion may only be issued if its response has somewhere to land.
  assign slot_free = !rsp_valid_q || bus_io.rsp_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bus_io.req_write, bus_io.req_addr, bus_io.req_wdata};
    end
  end

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    m_start_d   = 1'b0;
    m_write_d   = m_write_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    rsp_valid_d = rsp_valid_q && !bus_io.rsp_ready;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB_REQ_SEQ_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (!empty && slot_free) begin
          pop                             = 1'b1;
          {m_write_d, m_addr_d, m_wdata_d} = mem_q[rd_ptr_q];
          m_start_d                       = 1'b1;
          state_d                         = StIssue;
        end
      end
      StIssue: begin
        state_d = StWait;
`ifdef APB_REQ_SEQ_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end
      StWait: begin
        if (bus_io.m_pready) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = m_write_q ? '0 : bus_io.m_prdata;
          rsp_err_d   = bus_io.m_pslverr;
          state_d     = StIdle;
        end
`ifdef APB_REQ_SEQ_TIMEOUT_EN
        else if (tmo_cnt_q == TmoW'(TIMEOUT - 1)) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = StIdle;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TmoW'(1);
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      m_start_q   <= 1'b0;
      m_write_q   <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q     <= count_q + CntW'(push) - CntW'(pop);
      m_start_q   <= m_start_d;
      m_write_q   <= m_write_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

`ifdef APB_REQ_SEQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) tmo_cnt_q <= '0;
    else       tmo_cnt_q <= tmo_cnt_d;
  end
`endif

  assign bus_io.req_ready  = !full;
  assign bus_io.fifo_count = count_q;
  assign bus_io.busy       = (state_q != StIdle) || !empty;
  assign bus_io.m_start    = m_start_q;
  assign bus_io.m_write    = m_write_q;
  assign bus_io.m_addr     = m_addr_q;
  assign bus_io.m_wdata    = m_wdata_q;
  assign bus_io.rsp_valid  = rsp_valid_q;
  assign bus_io.rsp_rdata  = rsp_rdata_q;
  assign bus_io.rsp_err    = rsp_err_q;
endmodule

// File: tb/tb_apb_req_sequencer.sv
// Bench for apb_req_sequencer: queue-based reference model checked every cycle, a scripted
// apb_master responder, and directed scenarios with literal expectations.
module tb_apb_req_sequencer;
  localparam int unsigned AW = 8, DW = 8, DEPTH = 4, TIMEOUT = 16;

  typedef struct packed {logic w; logic [AW-1:0] a; logic [DW-1:0] d;} req_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  bit   chk_en = 1'b0;

  apb_req_sequencer_if #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) bus ();

  apb_req_sequencer #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, got, exp);
    end
  endtask

  // ---------------- reference model (updated on each rising edge) ----------------
  req_t          mq[$];
  int            phase = 0;          // 0 idle, 1 start pulse, 2 waiting for completion
  int            wcnt = 0;
  bit            e_start = 0;
  req_t          e_cmd = '0;
  bit            e_rv = 0;
  logic [DW-1:0] e_rd = '0;
  bit            e_re = 0;
  logic [DW-1:0] rsp_log_d[$];
  bit            rsp_log_e[$];
  bit            m_done, m_slot, m_acc, m_ne;
  logic [DW-1:0] m_nd;
  req_t          m_in;

  always @(posedge clk) begin
    m_in  = {bus.req_write, bus.req_addr, bus.req_wdata};
    if (reset) begin
      mq.delete();
      phase = 0; wcnt = 0; e_start = 0; e_cmd = '0; e_rv = 0; e_rd = '0; e_re = 0;
    end else begin
      m_done = 0; m_nd = '0; m_ne = 0;
      if (e_rv && bus.rsp_ready) begin
        rsp_log_d.push_back(e_rd);
        rsp_log_e.push_back(e_re);
      end
      m_slot  = !e_rv || bus.rsp_ready;
      m_acc   = bus.req_valid && (mq.size() < DEPTH);
      e_start = 0;
      if (phase == 0) begin
        if (mq.size() > 0 && m_slot) begin
          e_cmd = mq.pop_front();
          e_start = 1;
          phase = 1;
        end
      end else if (phase == 1) begin
        phase = 2;
        wcnt = 0;
      end else begin
        if (bus.m_pready) begin
          m_done = 1; m_nd = e_cmd.w ? '0 : bus.m_prdata; m_ne = bus.m_pslverr;
        end
`ifdef APB_REQ_SEQ_TIMEOUT_EN
        else if (wcnt + 1 == TIMEOUT) begin
          m_done = 1; m_nd = '0; m_ne = 1;
        end else wcnt++;
`endif
        if (m_done) phase = 0;
      end
      if (m_done) begin
        e_rv = 1; e_rd = m_nd; e_re = m_ne;
      end else if (bus.rsp_ready) e_rv = 0;
      if (m_acc) mq.push_back(m_in);
    end
  end

  // ---------------- compare process (outputs sampled on falling edge) ----------------
  req_t start_log[$];

  always @(negedge clk) begin
    if (bus.m_start) start_log.push_back({bus.m_write, bus.m_addr, bus.m_wdata});
    if (chk_en) begin
      chk("fifo_count", 32'(bus.fifo_count), 32'(mq.size()));
      chk("req_ready", 32'(bus.req_ready), 32'(mq.size() < DEPTH));
      chk("busy", 32'(bus.busy), 32'((phase != 0) || (mq.size() != 0)));
      chk("m_start", 32'(bus.m_start), 32'(e_start));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(e_rv));
      if (phase != 0) chk("m_cmd", 32'({bus.m_write, bus.m_addr, bus.m_wdata}), 32'(e_cmd));
      if (e_rv) begin
        chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(e_rd));
        chk("rsp_err", 32'(bus.rsp_err), 32'(e_re));
      end
    end
  end

  // ---------------- scripted apb_master responder ----------------
  bit            slv_on = 0;
  int            slv_delay = 2;
  logic [DW-1:0] slv_data[$];
  bit            slv_err[$];
  int            late_req = 0;

  initial begin
    int cnt = 0;
    int late_seen = 0;
    bus.m_pready = 1'b0; bus.m_prdata = '0; bus.m_pslverr = 1'b0;
    forever begin
      @(negedge clk);
      bus.m_pready = 1'b0;
      if (late_req != late_seen) begin
        late_seen = late_req;
        bus.m_pready = 1'b1; bus.m_prdata = 8'hEE; bus.m_pslverr = 1'b0;
      end else if (slv_on && bus.m_start) begin
        cnt = slv_delay;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.m_pready  = 1'b1;
          bus.m_prdata  = (slv_data.size() > 0) ? slv_data.pop_front() : '0;
          bus.m_pslverr = (slv_err.size() > 0) ? slv_err.pop_front() : 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic push(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_addr = a; bus.req_wdata = d;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int maxc);
    int k = 0;
    while (!bus.rsp_valid && k < maxc) begin
      @(negedge clk);
      k++;
    end
    chk("rsp_wait", 32'(bus.rsp_valid), 32'd1);
  endtask

  task automatic wait_log(input int n, input int maxc, output bit ok);
    int k = 0;
    while (rsp_log_d.size() < n && k < maxc) begin
      @(negedge clk);
      k++;
    end
    ok = (rsp_log_d.size() >= n);
    chk("rsp_log_wait", 32'(ok), 32'd1);
  endtask

  initial begin
    int sb, rb, k, n;
    bit ok, seen;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;

    // Reset and idle
    @(negedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_fifo_count", 32'(bus.fifo_count), 32'd0);
    chk("rst_m_start", 32'(bus.m_start), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_m_addr", 32'(bus.m_addr), 32'd0);

    // Single write; write response must report zero data
    slv_on = 1; slv_delay = 2;
    slv_data.push_back(8'h33); slv_err.push_back(1'b0);
    push(1'b1, 8'h10, 8'hFF);
    wait_rsp(20);
    chk("wr_rdata", 32'(bus.rsp_rdata), 32'h00);
    chk("wr_err", 32'(bus.rsp_err), 32'd0);
    chk("wr_nstart", 32'(start_log.size()), 32'd1);
    if (start_log.size() >= 1) chk("wr_cmd", 32'(start_log[0]), 32'h1_10FF);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("wr_consumed", 32'(bus.rsp_valid), 32'd0);

    // Two back-to-back reads in order
    sb = start_log.size(); rb = rsp_log_d.size();
    slv_data.push_back(8'hFF); slv_err.push_back(1'b0);
    slv_data.push_back(8'hA5); slv_err.push_back(1'b0);
    push(1'b0, 8'h10, 8'h00);
    push(1'b0, 8'h80, 8'h00);
    wait_log(rb + 2, 40, ok);
    if (ok) begin
      chk("rd2_rsp0", 32'(rsp_log_d[rb]), 32'hFF);
      chk("rd2_rsp1", 32'(rsp_log_d[rb + 1]), 32'hA5);
      chk("rd2_nstart", 32'(start_log.size() - sb), 32'd2);
      chk("rd2_addr0", 32'(start_log[sb].a), 32'h10);
      chk("rd2_addr1", 32'(start_log[sb + 1].a), 32'h80);
    end

    // Stalled response slot: fill FIFO, fifth push refused
    bus.rsp_ready = 1'b0;
    sb = start_log.size(); rb = rsp_log_d.size();
    slv_data.push_back(8'h01); slv_err.push_back(1'b0);
    push(1'b0, 8'h20, 8'h00);
    wait_rsp(20);
    for (int i = 2; i <= 5; i++) begin
      slv_data.push_back(8'(i)); slv_err.push_back(1'b0);
    end
    for (int i = 1; i <= 5; i++) push(1'b0, 8'(8'h20 + i), 8'h00);
    chk("full_count", 32'(bus.fifo_count), 32'd4);
    chk("full_ready", 32'(bus.req_ready), 32'd0);
    repeat (10) @(negedge clk);
    chk("stall_nstart", 32'(start_log.size() - sb), 32'd1);
    bus.rsp_ready = 1'b1;
    wait_log(rb + 5, 120, ok);
    if (ok) begin
      chk("drain_first", 32'(rsp_log_d[rb]), 32'h01);
      chk("drain_last", 32'(rsp_log_d[rb + 4]), 32'h05);
      chk("drain_nstart", 32'(start_log.size() - sb), 32'd5);
      chk("drain_last_addr", 32'(start_log[sb + 4].a), 32'h24);
    end
    @(negedge clk);
    chk("drain_busy", 32'(bus.busy), 32'd0);

    // Read with slave error
    slv_data.push_back(8'h5A); slv_err.push_back(1'b1);
    push(1'b0, 8'h80, 8'h00);
    wait_rsp(20);
    chk("err_rdata", 32'(bus.rsp_rdata), 32'h5A);
    chk("err_flag", 32'(bus.rsp_err), 32'd1);
    @(negedge clk);

    // Reset during WAIT with two queued, then a late pready
    slv_on = 0;
    push(1'b0, 8'h30, 8'h00);
    push(1'b0, 8'h31, 8'h00);
    push(1'b0, 8'h32, 8'h00);
    repeat (4) @(negedge clk);
    chk("mid_count", 32'(bus.fifo_count), 32'd2);
    chk("mid_busy", 32'(bus.busy), 32'd1);
    sb = start_log.size(); rb = rsp_log_d.size();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    late_req++;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1;
    end
    chk("rst_mid_count", 32'(bus.fifo_count), 32'd0);
    chk("rst_mid_rsp_seen", 32'(seen), 32'd0);
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    chk("rst_mid_nstart", 32'(start_log.size() - sb), 32'd0);

`ifdef APB_REQ_SEQ_TIMEOUT_EN
    // No pready: timeout completion TIMEOUT cycles after entering WAIT
    push(1'b0, 8'h40, 8'h00);
    k = 0;
    while (!bus.m_start && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("tmo_start", 32'(bus.m_start), 32'd1);
    n = 0;
    while (!bus.rsp_valid && n < TIMEOUT + 5) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_latency", 32'(n), 32'(TIMEOUT + 1));
    chk("tmo_err", 32'(bus.rsp_err), 32'd1);
    chk("tmo_rdata", 32'(bus.rsp_rdata), 32'h00);
`else
    // No pready and no timeout: the transfer must stay outstanding
    push(1'b0, 8'h41, 8'h00);
    seen = 0;
    repeat (3 * TIMEOUT) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1;
    end
    chk("notmo_rsp_seen", 32'(seen), 32'd0);
    chk("notmo_busy", 32'(bus.busy), 32'd1);
    k = 0; n = 0;
`endif
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
